apb_timer_param: RTL and testbench
==================================

APB_TIMER_PARAM -- requirements
Module: apb_timer_param

Interface
REQ-001 Parameter WIDTH, default 8, counter/register/data-bus width (legal 8..32).
REQ-002 Parameter ADDR_W, default 8, APB address width.
REQ-003 pclk  input  1  APB/system clock; one clock, all logic rises on pclk.
REQ-004 presetn  input  1  reset, asynchronous, active-low.
REQ-005 psel, penable, pwrite  input  1 each  APB control.
REQ-006 paddr  input  ADDR_W  byte address.
REQ-007 pwdata  input  WIDTH  write data.
REQ-008 prdata  output  WIDTH  read data, valid while psel&penable&!pwrite.
REQ-009 pready  output  1  constant 1 (zero wait state).
REQ-010 pslverr  output  1  1 during access phase to an unmapped address.
REQ-011 irq  output  1  OR of (TSR flags AND their enables), registered.

Function
REQ-012 Access phase = psel&penable; writes commit on that pclk edge; unmapped writes are ignored; unmapped reads return 0.
REQ-013 Map: 0x00 TDR (RW, reload value), 0x04 TCR (RW), 0x08 TSR (R/W1C), 0x0C TCNT (RO), 0x10 TCMP (RW, compare value).
REQ-014 TCR bits: [0] load, [1] dir (0 up, 1 down), [2] en, [4:3] cks, [5] ovf_ie, [6] udf_ie, [7] cmp_ie; bits above 7 read 0.
REQ-015 TCR.load is self-clearing: on the cycle after it is written as 1, TCNT=TDR and load reads 0.
REQ-016 Prescaler issues a 1-cycle tick every 2^(cks+1) pclk cycles (cks 0..3 -> 2,4,8,16); first tick occurs 2^(cks+1) cycles after en rises.
REQ-017 Prescaler is cleared while en=0, while load=1, and on any TCR write that changes cks.
REQ-018 On tick with en=1, load=0, dir=0: TCNT<=TCNT+1; if TCNT is all-ones, TCNT<=TDR and TSR.ovf<=1.
REQ-019 On tick with en=1, load=0, dir=1: TCNT<=TCNT-1; if TCNT is 0, TCNT<=TDR and TSR.udf<=1.
REQ-020 TSR.cmp<=1 on the cycle TCNT is updated (tick or load) to a value equal to TCMP.
REQ-021 Priority per cycle: reset > load > tick count; tick coincident with load is discarded.
REQ-022 TSR write of 1 clears the corresponding flag; a hardware set in the same cycle wins (flag stays 1).
REQ-023 TDR/TCMP writes take effect next cycle and never modify TCNT directly.
REQ-024 irq updates one cycle after a flag or enable change.
REQ-025 All arithmetic is WIDTH bits, modulo 2^WIDTH; no sign semantics.
REQ-026 Changing dir while counting takes effect on the next tick; no flag is generated by the change.

Reset
REQ-027 presetn low asynchronously clears TDR, TCR, TSR, TCNT, TCMP, prescaler and irq to 0; prdata=0, pslverr=0, pready=1.
REQ-028 Reset asserted mid-count aborts counting immediately; after release the timer stays idle until en is written.

Structure
REQ-029 Shared package apb_timer_pkg holds register offsets, TCR/TSR bit indices and the cks encoding.
REQ-030 One sub-module, timer_prescaler (inputs en, clr, cks; output tick).

Verification
REQ-031 WIDTH=8: 20 random TDR/TCMP write-then-read -> readback equals write; read 0x14 -> prdata=0, pslverr=1.
REQ-032 WIDTH=8: TDR=0xFA, load, TCR en=1 dir=0 cks=0 -> TCNT reaches 0xFF after 10 pclk, next tick TCNT=0xFA, ovf=1, irq=1 if ovf_ie.
REQ-033 WIDTH=16: TDR=0x0003, load, dir=1, cks=3 -> TCNT decrements every 16 cycles, udf=1 at 0x0000->0x0003 after 64 cycles.
REQ-034 TCMP=0x05, TDR=0x00, count up -> cmp=1 when TCNT=0x05; W1C TSR=0x4 coincident with a new set -> flag stays 1.
REQ-035 Assert presetn mid-count (TCNT=0x37) -> all registers 0 same cycle, TCNT holds 0 after release.

Source files
------------

// File: rtl/apb_timer_param_pkg.sv
// Shared definitions for the APB timer: register offsets, TCR/TSR bit positions
// and the prescaler divider encoding.
package apb_timer_pkg;

    localparam int unsigned TDR_OFF  = 32'h00;
    localparam int unsigned TCR_OFF  = 32'h04;
    localparam int unsigned TSR_OFF  = 32'h08;
    localparam int unsigned TCNT_OFF = 32'h0C;
    localparam int unsigned TCMP_OFF = 32'h10;

    localparam int TCR_LOAD   = 0;
    localparam int TCR_DIR    = 1;
    localparam int TCR_EN     = 2;
    localparam int TCR_CKS_LO = 3;
    localparam int TCR_CKS_HI = 4;
    localparam int TCR_OVF_IE = 5;
    localparam int TCR_UDF_IE = 6;
    localparam int TCR_CMP_IE = 7;
    localparam int TCR_W      = 8;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;
    localparam int TSR_CMP = 2;
    localparam int TSR_W   = 3;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'd0,
        CKS_DIV4  = 2'd1,
        CKS_DIV8  = 2'd2,
        CKS_DIV16 = 2'd3
    } cks_e;

    // Terminal prescaler count for a divider setting (period minus one).
    function automatic logic [3:0] cks_last(cks_e cks);
        logic [3:0] last;
        case (cks)
            CKS_DIV2:  last = 4'd1;
            CKS_DIV4:  last = 4'd3;
            CKS_DIV8:  last = 4'd7;
            default:   last = 4'd15;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/apb_timer_param_if.sv
// APB slave bus bundle for the timer, with master and slave views.
interface apb_timer_param_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [WIDTH-1:0]  pwdata;
    logic [WIDTH-1:0]  prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timer_param_prescaler.sv
// Clock prescaler: one-cycle tick every 2^(cks+1) cycles while enabled,
// restarting from zero whenever cleared or disabled.
module timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        tick  = en && !clr && (cnt_q == cks_last(cks_e'(cks)));
        cnt_d = cnt_q + 4'd1;
        if (!en || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer_param.sv
// APB-mapped up/down timer with reload, compare, W1C status flags and a
// registered interrupt output.
module apb_timer_param
    import apb_timer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_timer_param_if.slave     bus,
    output logic                 irq
);

    logic [WIDTH-1:0]  tdr_q,  tdr_d;
    logic [WIDTH-1:0]  tcmp_q, tcmp_d;
    logic [WIDTH-1:0]  tcnt_q, tcnt_d;
    logic [TCR_W-1:0]  tcr_q,  tcr_d;
    logic [TSR_W-1:0]  tsr_q,  tsr_d;
    logic              irq_q,  irq_d;

    logic             access, wr, rd;
    logic             sel_tdr, sel_tcr, sel_tsr, sel_tcnt, sel_tcmp, mapped;
    logic             cks_chg, tick, cnt_upd;
    logic [TSR_W-1:0] hw_set, irq_en;
    logic [WIDTH-1:0] rdata;

    assign access   = bus.psel & bus.penable;
    assign wr       = access & bus.pwrite;
    assign rd       = access & ~bus.pwrite;

    assign sel_tdr  = (bus.paddr == ADDR_W'(TDR_OFF));
    assign sel_tcr  = (bus.paddr == ADDR_W'(TCR_OFF));
    assign sel_tsr  = (bus.paddr == ADDR_W'(TSR_OFF));
    assign sel_tcnt = (bus.paddr == ADDR_W'(TCNT_OFF));
    assign sel_tcmp = (bus.paddr == ADDR_W'(TCMP_OFF));
    assign mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tcnt | sel_tcmp;

    // A divider change restarts the prescaler so the new period starts clean.
    assign cks_chg  = wr && sel_tcr &&
                      (bus.pwdata[TCR_CKS_HI:TCR_CKS_LO] != tcr_q[TCR_CKS_HI:TCR_CKS_LO]);

    assign irq_en   = {tcr_q[TCR_CMP_IE], tcr_q[TCR_UDF_IE], tcr_q[TCR_OVF_IE]};

    timer_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (tcr_q[TCR_EN]),
        .clr     (tcr_q[TCR_LOAD] | cks_chg),
        .cks     (tcr_q[TCR_CKS_HI:TCR_CKS_LO]),
        .tick    (tick)
    );

    always_comb begin
        tdr_d   = tdr_q;
        tcmp_d  = tcmp_q;
        tcr_d   = tcr_q;
        tcnt_d  = tcnt_q;
        hw_set  = '0;
        cnt_upd = 1'b0;

        if (wr && sel_tdr)  tdr_d  = bus.pwdata;
        if (wr && sel_tcmp) tcmp_d = bus.pwdata;

        if (tcr_q[TCR_LOAD]) tcr_d[TCR_LOAD] = 1'b0;
        if (wr && sel_tcr)   tcr_d = bus.pwdata[TCR_W-1:0];

        // Load outranks a coincident tick, which is simply dropped.
        if (tcr_q[TCR_LOAD]) begin
            tcnt_d  = tdr_q;
            cnt_upd = 1'b1;
        end else if (tick) begin
            cnt_upd = 1'b1;
            if (!tcr_q[TCR_DIR]) begin
                if (tcnt_q == '1) begin
                    tcnt_d          = tdr_q;
                    hw_set[TSR_OVF] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + WIDTH'(1);
                end
            end else begin
                if (tcnt_q == '0) begin
                    tcnt_d          = tdr_q;
                    hw_set[TSR_UDF] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - WIDTH'(1);
                end
            end
        end

        if (cnt_upd && (tcnt_d == tcmp_q)) hw_set[TSR_CMP] = 1'b1;

        // Hardware sets are applied after the W1C so they win a collision.
        tsr_d = tsr_q;
        if (wr && sel_tsr) tsr_d = tsr_q & ~bus.pwdata[TSR_W-1:0];
        tsr_d = tsr_d | hw_set;

        irq_d = |(tsr_q & irq_en);
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_tdr)  rdata = tdr_q;
            if (sel_tcr)  rdata = WIDTH'(tcr_q);
            if (sel_tsr)  rdata = WIDTH'(tsr_q);
            if (sel_tcnt) rdata = tcnt_q;
            if (sel_tcmp) rdata = tcmp_q;
        end
    end

    assign bus.prdata  = rdata;
    assign bus.pready  = 1'b1;
    assign bus.pslverr = access & ~mapped;
    assign irq         = irq_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q  <= '0;
            tcmp_q <= '0;
            tcnt_q <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            tdr_q  <= tdr_d;
            tcmp_q <= tcmp_d;
            tcnt_q <= tcnt_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            irq_q  <= irq_d;
        end
    end

endmodule

// File: tb/tb_apb_timer_param.sv
// Directed bench for apb_timer_param: an 8-bit and a 16-bit instance driven
// over APB with hand-computed expectations.
module tb_apb_timer_param;

    localparam logic [7:0] A_TDR  = 8'h00;
    localparam logic [7:0] A_TCR  = 8'h04;
    localparam logic [7:0] A_TSR  = 8'h08;
    localparam logic [7:0] A_TCNT = 8'h0C;
    localparam logic [7:0] A_TCMP = 8'h10;
    localparam logic [7:0] A_BAD  = 8'h14;

    logic pclk;
    logic presetn;
    logic irq8;
    logic irq16;

    int n_checks = 0;
    int n_errors = 0;

    apb_timer_param_if #(.WIDTH(8),  .ADDR_W(8)) bus8 ();
    apb_timer_param_if #(.WIDTH(16), .ADDR_W(8)) bus16 ();

    apb_timer_param #(.WIDTH(8), .ADDR_W(8)) dut8 (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus8),
        .irq     (irq8)
    );

    apb_timer_param #(.WIDTH(16), .ADDR_W(8)) dut16 (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus16),
        .irq     (irq16)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Writes commit on the second rising edge after the call.
    task automatic wr8(input logic [7:0] a, input logic [7:0] d);
        bus8.psel = 1'b1; bus8.penable = 1'b0; bus8.pwrite = 1'b1;
        bus8.paddr = a;   bus8.pwdata = d;
        @(posedge pclk); #1 bus8.penable = 1'b1;
        @(posedge pclk); #1 bus8.psel = 1'b0; bus8.penable = 1'b0; bus8.pwrite = 1'b0;
    endtask

    task automatic rd8(input logic [7:0] a, output logic [7:0] d, output logic err);
        bus8.psel = 1'b1; bus8.penable = 1'b0; bus8.pwrite = 1'b0; bus8.paddr = a;
        @(posedge pclk); #1 bus8.penable = 1'b1;
        #1 d = bus8.prdata; err = bus8.pslverr;
        @(posedge pclk); #1 bus8.psel = 1'b0; bus8.penable = 1'b0;
    endtask

    task automatic wr16(input logic [7:0] a, input logic [15:0] d);
        bus16.psel = 1'b1; bus16.penable = 1'b0; bus16.pwrite = 1'b1;
        bus16.paddr = a;   bus16.pwdata = d;
        @(posedge pclk); #1 bus16.penable = 1'b1;
        @(posedge pclk); #1 bus16.psel = 1'b0; bus16.penable = 1'b0; bus16.pwrite = 1'b0;
    endtask

    task automatic rd16(input logic [7:0] a, output logic [15:0] d);
        bus16.psel = 1'b1; bus16.penable = 1'b0; bus16.pwrite = 1'b0; bus16.paddr = a;
        @(posedge pclk); #1 bus16.penable = 1'b1;
        #1 d = bus16.prdata;
        @(posedge pclk); #1 bus16.psel = 1'b0; bus16.penable = 1'b0;
    endtask

    initial begin
        logic [7:0]  d8;
        logic [7:0]  v;
        logic [15:0] d16;
        logic        err;

        presetn = 1'b0;
        bus8.psel = 1'b0;  bus8.penable = 1'b0;  bus8.pwrite = 1'b0;
        bus8.paddr = '0;   bus8.pwdata = '0;
        bus16.psel = 1'b0; bus16.penable = 1'b0; bus16.pwrite = 1'b0;
        bus16.paddr = '0;  bus16.pwdata = '0;

        #2;
        check_eq("rst_pready",  32'(bus8.pready), 32'h1);
        check_eq("rst_prdata",  32'(bus8.prdata), 32'h0);
        check_eq("rst_pslverr", 32'(bus8.pslverr), 32'h0);
        check_eq("rst_irq",     32'(irq8), 32'h0);

        repeat (3) @(posedge pclk);
        #3 presetn = 1'b1;
        @(posedge pclk); #1;

        rd8(A_TDR,  d8, err); check_eq("rst_tdr",  32'(d8), 32'h0);
        rd8(A_TCR,  d8, err); check_eq("rst_tcr",  32'(d8), 32'h0);
        rd8(A_TSR,  d8, err); check_eq("rst_tsr",  32'(d8), 32'h0);
        rd8(A_TCNT, d8, err); check_eq("rst_tcnt", 32'(d8), 32'h0);
        rd8(A_TCMP, d8, err); check_eq("rst_tcmp", 32'(d8), 32'h0);
        check_eq("map_slverr", 32'(err), 32'h0);

        // Register readback with random data.
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom_range(0, 255));
            wr8(A_TDR, v);
            rd8(A_TDR, d8, err);
            check_eq("tdr_rb", 32'(d8), 32'(v));
            v = 8'($urandom_range(0, 255));
            wr8(A_TCMP, v);
            rd8(A_TCMP, d8, err);
            check_eq("tcmp_rb", 32'(d8), 32'(v));
        end
        rd8(A_BAD, d8, err);
        check_eq("bad_prdata",  32'(d8), 32'h0);
        check_eq("bad_pslverr", 32'(err), 32'h1);

        // Self-clearing load copies TDR into TCNT.
        wr8(A_TDR, 8'h11);
        wr8(A_TCR, 8'h01);
        rd8(A_TCR,  d8, err); check_eq("load_selfclr", 32'(d8), 32'h0);
        rd8(A_TCNT, d8, err); check_eq("load_tcnt",    32'(d8), 32'h11);

        // Up count from 0xFA, cks=0, overflow with ovf_ie.
        wr8(A_TDR, 8'hFA);
        wr8(A_TCR, 8'h01);
        wr8(A_TCR, 8'h24);
        check_eq("up_start", 32'(dut8.tcnt_q), 32'hFA);
        repeat (9) @(posedge pclk); #1;
        check_eq("up_e9",    32'(dut8.tcnt_q), 32'hFE);
        @(posedge pclk); #1;
        check_eq("up_e10",   32'(dut8.tcnt_q), 32'hFF);
        repeat (2) @(posedge pclk); #1;
        check_eq("ovf_wrap", 32'(dut8.tcnt_q), 32'hFA);
        check_eq("ovf_flag", 32'(dut8.tsr_q[0]), 32'h1);
        check_eq("ovf_irq_lag", 32'(irq8), 32'h0);
        @(posedge pclk); #1;
        check_eq("ovf_irq",  32'(irq8), 32'h1);

        wr8(A_TCR, 8'h00);
        wr8(A_TSR, 8'h07);
        rd8(A_TSR, d8, err); check_eq("tsr_clr", 32'(d8), 32'h0);
        check_eq("irq_off", 32'(irq8), 32'h0);

        // Compare flag, W1C colliding with a hardware set.
        wr8(A_TDR,  8'h00);
        wr8(A_TCMP, 8'h05);
        wr8(A_TCR,  8'h01);
        wr8(A_TCR,  8'h04);
        check_eq("cmp_start", 32'(dut8.tcnt_q), 32'h0);
        repeat (8) @(posedge pclk); #1;
        check_eq("cmp_pre_cnt",  32'(dut8.tcnt_q), 32'h4);
        check_eq("cmp_pre_flag", 32'(dut8.tsr_q[2]), 32'h0);
        wr8(A_TSR, 8'h04);
        check_eq("cmp_cnt",      32'(dut8.tcnt_q), 32'h5);
        check_eq("cmp_w1c_race", 32'(dut8.tsr_q[2]), 32'h1);
        wr8(A_TSR, 8'h04);
        check_eq("cmp_cnt6",     32'(dut8.tcnt_q), 32'h6);
        check_eq("cmp_w1c",      32'(dut8.tsr_q[2]), 32'h0);
        wr8(A_TCR, 8'h00);

        // 16-bit down count, cks=3, underflow with udf_ie.
        wr16(A_TDR, 16'h0003);
        wr16(A_TCR, 16'h0001);
        wr16(A_TCR, 16'h005E);
        check_eq("dn_start", 32'(dut16.tcnt_q), 32'h3);
        repeat (15) @(posedge pclk); #1;
        check_eq("dn_e15",   32'(dut16.tcnt_q), 32'h3);
        @(posedge pclk); #1;
        check_eq("dn_e16",   32'(dut16.tcnt_q), 32'h2);
        repeat (16) @(posedge pclk); #1;
        check_eq("dn_e32",   32'(dut16.tcnt_q), 32'h1);
        repeat (16) @(posedge pclk); #1;
        check_eq("dn_e48",   32'(dut16.tcnt_q), 32'h0);
        repeat (15) @(posedge pclk); #1;
        check_eq("dn_e63",   32'(dut16.tcnt_q), 32'h0);
        check_eq("udf_early", 32'(dut16.tsr_q[1]), 32'h0);
        @(posedge pclk); #1;
        check_eq("udf_wrap", 32'(dut16.tcnt_q), 32'h3);
        check_eq("udf_flag", 32'(dut16.tsr_q[1]), 32'h1);
        check_eq("udf_no_ovf", 32'(dut16.tsr_q[0]), 32'h0);
        @(posedge pclk); #1;
        check_eq("udf_irq",  32'(irq16), 32'h1);
        wr16(A_TCR, 16'h0000);
        rd16(A_TCNT, d16);
        check_eq("dn_rd_tcnt", 32'(d16), 32'h3);

        // Asynchronous reset in the middle of a count.
        wr8(A_TDR, 8'h30);
        wr8(A_TCR, 8'h01);
        wr8(A_TCR, 8'h04);
        repeat (14) @(posedge pclk); #1;
        check_eq("mid_tcnt", 32'(dut8.tcnt_q), 32'h37);
        #2 presetn = 1'b0;
        #1;
        check_eq("arst_tcnt", 32'(dut8.tcnt_q), 32'h0);
        check_eq("arst_tdr",  32'(dut8.tdr_q),  32'h0);
        check_eq("arst_tcr",  32'(dut8.tcr_q),  32'h0);
        check_eq("arst_tcmp", 32'(dut8.tcmp_q), 32'h0);
        check_eq("arst_tsr",  32'(dut8.tsr_q),  32'h0);
        check_eq("arst_irq",  32'(irq8), 32'h0);
        #3 presetn = 1'b1;
        repeat (10) @(posedge pclk); #1;
        check_eq("post_tcnt", 32'(dut8.tcnt_q), 32'h0);
        rd8(A_TCNT, d8, err); check_eq("post_rd_tcnt", 32'(d8), 32'h0);
        rd8(A_TCR,  d8, err); check_eq("post_rd_tcr",  32'(d8), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
